// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier stages: default operand widths,
// flat partial-product indexing and the Baugh-Wooley correction constant.
package dadda_pkg;

  localparam int DEF_WIDTH_A = 8;
  localparam int DEF_WIDTH_B = 8;

  // Flat bit position of row `row`, column `col` in the partial-product array.
  function automatic int pp_index(input int row, input int col, input int width_a);
    return row * width_a + col;
  endfunction

  // Modified Baugh-Wooley correction: 2^(WA+WB-1) + 2^(WA-1) + 2^(WB-1).
  // The two low terms are added, not OR-ed, so WA == WB carries into bit WA.
  // The sum always fits in WA+WB bits for widths >= 2; callers truncate to that.
  function automatic logic [63:0] bw_corr(input int width_a, input int width_b);
    return (64'd1 << (width_a + width_b - 1))
         + (64'd1 << (width_a - 1))
         + (64'd1 << (width_b - 1));
  endfunction

endpackage

// File: rtl/gen_partial_products_if.sv
// Operand/result bundle between the operand source and the partial-product
// stage. With GEN_PP_BAUGH_WOOLEY_EN defined, the bundle also carries pp_corr.
interface gen_partial_products_if
  import dadda_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
);

  logic                         in_valid;
  logic [WIDTH_A-1:0]           a;
  logic [WIDTH_B-1:0]           b;
  logic                         out_valid;
  logic [WIDTH_A*WIDTH_B-1:0]   pp;
`ifdef GEN_PP_BAUGH_WOOLEY_EN
  logic [WIDTH_A+WIDTH_B-1:0]   pp_corr;

  modport master (output in_valid, a, b, input out_valid, pp, pp_corr);
  modport slave  (input in_valid, a, b, output out_valid, pp, pp_corr);
`else
  modport master (output in_valid, a, b, input out_valid, pp);
  modport slave  (input in_valid, a, b, output out_valid, pp);
`endif

endinterface

// File: rtl/gen_partial_products_pp_row.sv
// One row of the partial-product array: a masked by a single multiplier bit.
// With GEN_PP_BAUGH_WOOLEY_EN, sign-row/sign-column cross terms are inverted.
module pp_row
  import dadda_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A
) (
  input  logic [WIDTH_A-1:0] a_i,
  input  logic               b_bit_i,
  input  logic               is_last_row_i,
  output logic [WIDTH_A-1:0] row_o
);

`ifndef GEN_PP_BAUGH_WOOLEY_EN
  // The row flag only matters for the signed array.
  logic unused_last_row;
  assign unused_last_row = is_last_row_i;
`endif

  // Form each row bit; the signed array flips a bit when exactly one of
  // "last row" and "last column" holds (never the corner bit).
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    row_o = '0;
    for (int j = 0; j < WIDTH_A; j++) begin
      row_o[j] = a_i[j] & b_bit_i;
`ifdef GEN_PP_BAUGH_WOOLEY_EN
      if (is_last_row_i != (j == WIDTH_A - 1)) row_o[j] = ~row_o[j];
`endif
    end
  end

endmodule

// File: rtl/gen_partial_products.sv
// Partial-product generation stage of the Dadda tree multiplier.
// Builds the WIDTH_B x WIDTH_A AND array, registers it with one cycle of
// latency and flags it valid. Row i sits at pp[i*WIDTH_A +: WIDTH_A]; bit j of
// row i has weight i+j. Both widths must be >= 2.
// Optional macro GEN_PP_BAUGH_WOOLEY_EN: signed (modified Baugh-Wooley) array
// plus a registered correction constant on pp_corr.
module gen_partial_products
  import dadda_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gen_partial_products_if.slave  bus
);

  logic [WIDTH_A-1:0]         rows [WIDTH_B];
  logic [WIDTH_A*WIDTH_B-1:0] pp_d;
  logic [WIDTH_A*WIDTH_B-1:0] pp_q;
  logic                       out_valid_q;

`ifdef GEN_PP_BAUGH_WOOLEY_EN
  localparam logic [WIDTH_A+WIDTH_B-1:0] PP_CORR =
    (WIDTH_A + WIDTH_B)'(bw_corr(WIDTH_A, WIDTH_B));
  logic [WIDTH_A+WIDTH_B-1:0] pp_corr_q;
`endif

  for (genvar i = 0; i < WIDTH_B; i++) begin : g_row
    pp_row #(.WIDTH_A(WIDTH_A)) u_row (
      .a_i           (bus.a),
      .b_bit_i       (bus.b[i]),
      .is_last_row_i (i == WIDTH_B - 1),
      .row_o         (rows[i])
    );
  end

  // Pack the rows into the flat array; no shifting, weight comes from row index.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH_B; i++) begin
      pp_d[pp_index(i, 0, WIDTH_A) +: WIDTH_A] = rows[i];
    end
  end

  // Capture the array only on valid operands; the flag follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so downstream sees a clean zero
      // array and a killed in-flight result rather than stale operands.
      pp_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef GEN_PP_BAUGH_WOOLEY_EN
      pp_corr_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        pp_q      <= pp_d;
`ifdef GEN_PP_BAUGH_WOOLEY_EN
        pp_corr_q <= PP_CORR;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pp        = pp_q;
`ifdef GEN_PP_BAUGH_WOOLEY_EN
  assign bus.pp_corr   = pp_corr_q;
`endif

endmodule

// File: tb/tb_gen_partial_products.sv
// Directed and random checks of the 8x8 partial-product stage.
module tb_gen_partial_products;
  import dadda_pkg::*;

  localparam int WA = DEF_WIDTH_A;
  localparam int WB = DEF_WIDTH_B;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gen_partial_products_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

  gen_partial_products #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
  endtask

  // Weighted sum of the array bits, mod 2^16.
  function automatic logic [15:0] wsum(input logic [63:0] p);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < WB; i++)
      for (int j = 0; j < WA; j++)
        if (p[i*WA + j]) s = s + (16'd1 << (i + j));
    return s;
  endfunction

  // Array value as the multiplier sees it (adds the correction in the signed build).
  function automatic logic [15:0] result_of();
`ifdef GEN_PP_BAUGH_WOOLEY_EN
    return wsum(bus.pp) + bus.pp_corr;
`else
    return wsum(bus.pp);
`endif
  endfunction

  function automatic logic [15:0] model_prod(input logic [7:0] av, input logic [7:0] bv);
`ifdef GEN_PP_BAUGH_WOOLEY_EN
    return {{8{av[7]}}, av} * {{8{bv[7]}}, bv};
`else
    return {8'h00, av} * {8'h00, bv};
`endif
  endfunction

`ifdef GEN_PP_BAUGH_WOOLEY_EN
  localparam logic [63:0] PP_ONES = 64'h807F_7F7F_7F7F_7F7F;
`else
  localparam logic [63:0] PP_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  logic        v;
  logic [7:0]  ra, rb;
  logic [15:0] last;

  initial begin
    drive(1'b1, 8'hFF, 8'hFF);
    #1 rst_n = 1'b0;

    // Reset held across several edges with valid all-ones operands.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_pp", bus.pp, 64'h0);
      check("rst_vld", bus.out_valid, 1'b0);
    end
`ifdef GEN_PP_BAUGH_WOOLEY_EN
    check("rst_corr", bus.pp_corr, 16'h0);
`endif
    rst_n = 1'b1;
    tick();
    check("first_pp", bus.pp, PP_ONES);
    check("first_vld", bus.out_valid, 1'b1);

`ifdef GEN_PP_BAUGH_WOOLEY_EN
    check("bw_ones_corr", bus.pp_corr, 16'h8100);
    check("bw_ones_sum", result_of(), 16'h0001);

    drive(1'b1, 8'h00, 8'h00);
    tick();
    check("bw_zero_pp", bus.pp, 64'h7F80_8080_8080_8080);
    check("bw_zero_sum", result_of(), 16'h0000);

    drive(1'b1, 8'h80, 8'h7F);
    tick();
    check("bw_mix_sum", result_of(), 16'hC080);
`else
    drive(1'b1, 8'h00, 8'h00);
    tick();
    check("zero_pp", bus.pp, 64'h0);
    check("zero_vld", bus.out_valid, 1'b1);

    drive(1'b1, 8'hFF, 8'hAA);
    tick();
    check("alt_pp", bus.pp, 64'hFF00_FF00_FF00_FF00);
    drive(1'b1, 8'hFF, 8'hFF);
    tick();
    check("b2b_pp", bus.pp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_vld", bus.out_valid, 1'b1);

    drive(1'b0, 8'h12, 8'h34);
    tick();
    check("gate_vld", bus.out_valid, 1'b0);
    check("gate_hold", bus.pp, 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1'b1, 8'h5A, 8'h01);
    tick();
    check("row0_pp", bus.pp, 64'h0000_0000_0000_005A);
    check("row0_vld", bus.out_valid, 1'b1);
`endif

    // Random operands with random valid; idle cycles must hold the last result.
    last = '0;
    for (int n = 0; n < 1000; n++) begin
      v  = (n == 0) || ($urandom_range(0, 3) != 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive(v, ra, rb);
      tick();
      if (v) last = model_prod(ra, rb);
      check("rnd_vld", bus.out_valid, v);
      check("rnd_sum", result_of(), last);
    end

    // Reset mid-cycle discards the in-flight operands immediately.
    drive(1'b1, 8'hFF, 8'hFF);
    #3 rst_n = 1'b0;
    #1;
    check("async_pp", bus.pp, 64'h0);
    check("async_vld", bus.out_valid, 1'b0);
    tick();
    check("async_hold_pp", bus.pp, 64'h0);
    rst_n = 1'b1;
    drive(1'b1, 8'h03, 8'h05);
    tick();
    check("post_rst_sum", result_of(), model_prod(8'h03, 8'h05));
    check("post_rst_vld", bus.out_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_partial_products.md
Name: gen_partial_products

Overview:
- Partial-product generation stage of the Dadda tree multiplier.
- Forms the AND array of operand A and operand B: row i is A masked by bit i of B.
- Registers the array and feeds it, with a valid flag, to the downstream Dadda reduction stages.
- Default build is unsigned 8x8.

Parameters:
- WIDTH_A, 8, width of multiplicand A; also the number of columns per row.
- WIDTH_B, 8, width of multiplier B; also the number of rows.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and B are valid this cycle.
- a  input  WIDTH_A  multiplicand.
- b  input  WIDTH_B  multiplier.
- out_valid  output  1  pp holds the array for the operands captured one cycle earlier.
- pp  output  WIDTH_A*WIDTH_B  flattened array; row i occupies pp[i*WIDTH_A +: WIDTH_A], and bit j of row i has column weight i+j.

Behaviour:
- Array definition (unsigned): row i, bit j = a[j] AND b[i], for 0<=i<WIDTH_B and 0<=j<WIDTH_A.
- Row i is therefore a when b[i]=1, and all zeros when b[i]=0.
- No shifting is applied inside a row; column alignment is implied by the row index.
- Latency: exactly one clock.
  - On a rising edge with in_valid=1: pp is loaded from the current a and b, and out_valid is set to 1.
  - On a rising edge with in_valid=0: out_valid is cleared to 0 and pp holds its previous value.
- No backpressure. A new operand pair can be accepted every cycle; back-to-back in_valid gives back-to-back results.
- Reset:
  - rst_n low forces pp=0 and out_valid=0 immediately, independent of clk.
  - Reset asserted mid-stream discards the in-flight result.
  - While rst_n is low, inputs are ignored.
  - The first capture happens on the first rising edge after rst_n goes high.
- Operands are sampled only when in_valid=1, so X on a and b while in_valid=0 must not propagate into pp.
- Boundary cases:
  - a=0 or b=0 gives an all-zero array.
  - a and b all ones gives an all-ones array.
  - WIDTH_A and WIDTH_B may differ; both must be >=2.

Optional Feature:
- Macro: GEN_PP_BAUGH_WOOLEY_EN.
- When defined, a and b are two's-complement and the array uses modified Baugh-Wooley form:
  - A bit is inverted exactly when one of (i==WIDTH_B-1) and (j==WIDTH_A-1) holds.
  - When both hold (i==WIDTH_B-1 and j==WIDTH_A-1), the bit is not inverted.
- When defined, an extra output port is added: pp_corr, output, WIDTH_A+WIDTH_B bits.
  - Registered alongside pp; reset value 0.
  - Once out_valid has been set, it holds the constant (2^(WIDTH_A+WIDTH_B-1) + 2^(WIDTH_A-1) + 2^(WIDTH_B-1)) mod 2^(WIDTH_A+WIDTH_B).
  - For 8x8 this is 0x8100.
- Invariant: the sum of all array bits at their weights plus pp_corr, mod 2^(WIDTH_A+WIDTH_B), equals the signed product.
- When undefined: unsigned array only, and no pp_corr port.

Decomposition:
- Shared package dadda_pkg holds:
  - the default width constants (8, 8);
  - a function returning the flat bit index of row i, column j;
  - the Baugh-Wooley correction-constant function.
- One natural sub-module: pp_row.
  - Combinational; one instance per row.
  - Inputs: a, one b bit, and an is_last_row flag.
  - Output: the row bits, including the conditional inversions.
- The top level holds the generate loop, the registers and the valid flag.

Test Plan:
- Reset: rst_n=0 with a=0xFF, b=0xFF, in_valid=1 -> pp=0 and out_valid=0 held for the whole reset; after release, the first edge yields pp = all ones and out_valid=1.
- Zero operands: a=0x00, b=0x00, in_valid=1 -> one cycle later pp=0 (all 64 bits) and out_valid=1.
- Alternating multiplier: a=0xFF, b=0xAA -> rows 1, 3, 5, 7 = 0xFF and rows 0, 2, 4, 6 = 0x00. Follow with b=0xFF (a still 0xFF) on the next cycle -> all rows 0xFF on consecutive cycles.
- Valid gating: in_valid=0 with a=0x12, b=0x34 after the previous step -> out_valid=0 and pp unchanged. Then a=0x5A, b=0x01, in_valid=1 -> row 0 = 0x5A and rows 1..7 = 0.
- Random check: 1000 random pairs with random in_valid -> the weighted sum of pp bits equals a*b (16-bit) for each valid result.
- GEN_PP_BAUGH_WOOLEY_EN:
  - a=0xFF, b=0xFF (-1 x -1) -> rows 0..6 = 0x7F, row 7 = 0x80, pp_corr = 0x8100, and weighted sum + pp_corr mod 2^16 = 0x0001.
  - a=0x80, b=0x7F -> weighted sum + pp_corr mod 2^16 = 0xC080.
